// File: rtl/ws2812_tx.sv
// ws2812_tx -- single-wire WS2812-style LED strip transmitter.
//
// Takes 24-bit GRB pixels over a valid/ready handshake and sends each one MSB
// first as pulse-width-coded bits. A 0 bit is high for c_t0h cycles and a 1 bit
// is high for c_t1h cycles. Every bit lasts c_tbit cycles. After a pixel
// flagged last, the line is held low for c_treset cycles so the strip latches.
// Only then is the next frame accepted.
//
// Ports:
//   i_clk    system clock
//   i_rst    synchronous reset, active-high; dominates every other input
//   i_data   pixel, GRB order, bit 23 sent first
//   i_valid  i_data / i_last valid
//   i_last   pixel is the final one of a frame
//   o_ready  a pixel can be accepted this cycle (combinational from state)
//   o_dout   registered serial data line to the strip
//   o_busy   high while sending or latching
module ws2812_tx #(
  parameter int unsigned c_freq   = 10000000,
  parameter int unsigned c_t0h    = 4,
  parameter int unsigned c_t1h    = 8,
  parameter int unsigned c_tbit   = 13,
  parameter int unsigned c_treset = 500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_dout,
  output logic        o_busy
);

  // One cycle counter serves both the bit period and the latch gap. It is
  // sized for the longer of the two, so neither terminal value is truncated.
  localparam int unsigned CNT_MAX = (c_tbit > c_treset) ? c_tbit : c_treset;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] TBIT_LAST   = CNT_W'(c_tbit - 1);
  localparam logic [CNT_W-1:0] TRESET_LAST = CNT_W'(c_treset - 1);
  localparam logic [CNT_W-1:0] T0H         = CNT_W'(c_t0h);
  localparam logic [CNT_W-1:0] T1H         = CNT_W'(c_t1h);

  if (!(c_freq > 0 && c_t0h >= 1 && c_t0h < c_t1h && c_t1h < c_tbit &&
        c_treset >= 1)) begin : g_bad_params
    $error("ws2812_tx: illegal timing parameters");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [23:0]      sr_q, sr_d;
  logic             last_q, last_d;
  logic             dout_q, dout_d;

  logic             bit_end;
  logic             pix_end;
  logic             ready;
  logic             take;

  assign bit_end = (cnt_q == TBIT_LAST);
  assign pix_end = bit_end && (bit_q == 5'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    last_d  = last_q;
    ready   = 1'b0;

    // Ready is open in IDLE. In SEND it is open only in the final cycle of a
    // non-last pixel, so the next pixel can follow with no gap.
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_SEND: ready = pix_end && !last_q;
      default: ready = 1'b0;
    endcase

    take = i_valid && ready;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_SEND;
          cnt_d   = '0;
          bit_d   = 5'd23;
          sr_d    = i_data;
          last_d  = i_last;
        end
      end

      ST_SEND: begin
        if (!bit_end) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (bit_q != 5'd0) begin
          cnt_d = '0;
          bit_d = bit_q - 5'd1;
          sr_d  = {sr_q[22:0], 1'b0};
        end else if (last_q) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end else if (take) begin
          // Seamless next pixel: bit 23 starts on the very next cycle.
          cnt_d  = '0;
          bit_d  = 5'd23;
          sr_d   = i_data;
          last_d = i_last;
        end else begin
          // Underrun: no pixel waiting, so park low in IDLE.
          state_d = ST_IDLE;
          cnt_d   = '0;
          bit_d   = 5'd0;
        end
      end

      ST_LATCH: begin
        if (cnt_q == TRESET_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = 5'd0;
      end
    endcase

    // The line is computed from the next-state values. The registered output
    // then lines up with the counter it describes, so the cycle after a
    // transfer already shows bit 23 high.
    dout_d = (state_d == ST_SEND) && (cnt_d < (sr_d[23] ? T1H : T0H));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 5'd0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
    end
  end

  // Pixel shift register and last flag carry data only. A reset returns the
  // FSM to IDLE, which makes their contents irrelevant.
  always_ff @(posedge i_clk) begin
    sr_q   <= sr_d;
    last_q <= last_d;
  end

  assign o_ready = ready;
  assign o_dout  = dout_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ws2812_tx.sv
`timescale 1ns/1ps
module tb_ws2812_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data;
  logic        last;
  logic        valid1, valid2;
  logic        ready1, dout1, busy1;
  logic        ready2, dout2, busy2;

  always #5 clk = ~clk;

  ws2812_tx u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid1), .i_last(last),
    .o_ready(ready1), .o_dout(dout1), .o_busy(busy1)
  );

  ws2812_tx #(.c_t0h(2), .c_t1h(5), .c_tbit(7), .c_treset(10)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid2), .i_last(last),
    .o_ready(ready2), .o_dout(dout2), .o_busy(busy2)
  );

  localparam int NMAX = 4096;

  int n_pass   = 0;
  int n_checks = 0;

  logic [23:0] feed_data [8];
  bit          feed_last [8];
  int          feed_gap  [8];
  int          feed_n;

  int exp_x [8];
  int act_x [8];
  int act_nx;
  int n_run;

  bit exp_dout [NMAX];
  bit exp_busy [NMAX];
  bit exp_ready[NMAX];
  bit act_dout [NMAX];
  bit act_busy [NMAX];
  bit act_ready[NMAX];

  // Reference model: the time of each transfer and the per-cycle line, busy
  // and ready. All of it is derived from the pulse timing rules alone.
  task automatic build_model(input int sel);
    int t0h, t1h, tbit, treset, present, earliest, plen, th, last_i;
    t0h    = sel ? 2 : 4;
    t1h    = sel ? 5 : 8;
    tbit   = sel ? 7 : 13;
    treset = sel ? 10 : 500;
    plen   = 24 * tbit;
    for (int i = 0; i < feed_n; i++) begin
      present  = (i == 0 ? 0 : exp_x[i-1] + 1) + feed_gap[i];
      earliest = (i == 0) ? 0 :
                 exp_x[i-1] + plen + (feed_last[i-1] ? treset + 1 : 0);
      exp_x[i] = (present > earliest) ? present : earliest;
    end
    last_i = feed_n - 1;
    n_run  = exp_x[last_i] + plen + (feed_last[last_i] ? treset : 0) + 4;
    if (n_run > NMAX) n_run = NMAX;
    for (int s = 0; s < NMAX; s++) begin
      exp_dout[s]  = 1'b0;
      exp_busy[s]  = 1'b0;
      exp_ready[s] = 1'b1;
    end
    for (int i = 0; i < feed_n; i++) begin
      for (int b = 0; b < 24; b++) begin
        th = feed_data[i][23-b] ? t1h : t0h;
        for (int k = 0; k < th; k++)
          if (exp_x[i] + b*tbit + k < NMAX) exp_dout[exp_x[i] + b*tbit + k] = 1'b1;
      end
      for (int s = exp_x[i]; s < exp_x[i] + plen + (feed_last[i] ? treset : 0); s++)
        if (s < NMAX) begin
          exp_busy[s]  = 1'b1;
          exp_ready[s] = 1'b0;
        end
      if (!feed_last[i] && exp_x[i] + plen - 1 < NMAX) exp_ready[exp_x[i] + plen - 1] = 1'b1;
    end
  endtask

  // Upstream source: presents each pixel feed_gap cycles after the previous
  // transfer, holds it until accepted, and records every cycle of the outputs.
  task automatic run(input int sel);
    int idx, wait_c;
    bit v, xfer;
    idx    = 0;
    wait_c = feed_gap[0];
    act_nx = 0;
    for (int c = 0; c < n_run; c++) begin
      v = (idx < feed_n) && (wait_c == 0);
      if (v) begin
        data = feed_data[idx];
        last = feed_last[idx];
      end
      valid1 = sel ? 1'b0 : v;
      valid2 = sel ? v : 1'b0;
      xfer   = v && (sel ? ready2 : ready1);
      @(posedge clk); #1;
      act_dout[c]  = sel ? dout2  : dout1;
      act_busy[c]  = sel ? busy2  : busy1;
      act_ready[c] = sel ? ready2 : ready1;
      if (xfer) begin
        if (act_nx < 8) act_x[act_nx] = c;
        act_nx++;
        idx++;
        if (idx < feed_n) wait_c = feed_gap[idx];
      end else if (idx < feed_n && wait_c > 0) begin
        wait_c--;
      end
    end
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  function automatic int first_bad();
    for (int s = 0; s < n_run; s++)
      if (act_dout[s] !== exp_dout[s] || act_busy[s] !== exp_busy[s] ||
          act_ready[s] !== exp_ready[s]) return s;
    return -1;
  endfunction

  function automatic bit xfers_ok();
    if (act_nx != feed_n) return 1'b0;
    for (int i = 0; i < feed_n; i++) if (act_x[i] != exp_x[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid1 = 1'b0; valid2 = 1'b0; data = '0; last = 1'b0;
    repeat (3) cyc();
    n_checks++; if (dout1 !== 1'b0) $display("FAIL reset_dout got %b want 0", dout1); else n_pass++;
    n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy1); else n_pass++;
    n_checks++; if (ready1 !== 1'b1) $display("FAIL reset_ready got %b want 1", ready1); else n_pass++;
    n_checks++; if ({dout2, busy2, ready2} !== 3'b001)
      $display("FAIL reset_dut2 dout/busy/ready got %b want 001", {dout2, busy2, ready2}); else n_pass++;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_pixel();
    int bad;
    feed_n = 1; feed_data[0] = 24'h800000; feed_last[0] = 1'b1; feed_gap[0] = 0;
    build_model(0); run(0);
    bad = first_bad();
    n_checks++;
    if (bad >= 0) $display("FAIL single_wave sample %0d dout/busy/ready got %b%b%b want %b%b%b", bad,
      act_dout[bad], act_busy[bad], act_ready[bad], exp_dout[bad], exp_busy[bad], exp_ready[bad]);
    else n_pass++;
    n_checks++;
    if (!xfers_ok()) $display("FAIL single_xfer got %0d transfers (first at %0d) want 1 at %0d",
      act_nx, act_x[0], exp_x[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad;
    feed_n = 4;
    feed_data[0] = 24'hFFFFFF; feed_last[0] = 1'b0;
    feed_data[1] = 24'h000000; feed_last[1] = 1'b1;
    feed_data[2] = 24'($urandom); feed_last[2] = 1'b0;
    feed_data[3] = 24'($urandom); feed_last[3] = 1'b1;
    for (int i = 0; i < 4; i++) feed_gap[i] = 0;
    build_model(0); run(0);
    bad = first_bad();
    n_checks++;
    if (bad >= 0) $display("FAIL b2b_wave sample %0d dout/busy/ready got %b%b%b want %b%b%b", bad,
      act_dout[bad], act_busy[bad], act_ready[bad], exp_dout[bad], exp_busy[bad], exp_ready[bad]);
    else n_pass++;
    n_checks++;
    if (!xfers_ok()) $display("FAIL b2b_xfer got %0d transfers want %0d at model times", act_nx, feed_n);
    else n_pass++;
    n_checks++;
    if (act_nx < 2 || act_x[1] - act_x[0] !== 312)
      $display("FAIL b2b_spacing got %0d want 312", (act_nx < 2) ? -1 : act_x[1] - act_x[0]);
    else n_pass++;
    n_checks++;
    if (act_nx < 3 || act_x[2] - act_x[1] !== 813)
      $display("FAIL latch_hold_spacing got %0d want 813", (act_nx < 3) ? -1 : act_x[2] - act_x[1]);
    else n_pass++;
  endtask

  task automatic test_underrun();
    int bad;
    feed_n = 2;
    feed_data[0] = 24'hAAAAAA;    feed_last[0] = 1'b0; feed_gap[0] = 0;
    feed_data[1] = 24'($urandom); feed_last[1] = 1'b1; feed_gap[1] = 311 + 21;
    build_model(0); run(0);
    bad = first_bad();
    n_checks++;
    if (bad >= 0) $display("FAIL underrun_wave sample %0d dout/busy/ready got %b%b%b want %b%b%b", bad,
      act_dout[bad], act_busy[bad], act_ready[bad], exp_dout[bad], exp_busy[bad], exp_ready[bad]);
    else n_pass++;
    n_checks++;
    if (!xfers_ok()) $display("FAIL underrun_xfer got %0d transfers want %0d at model times", act_nx, feed_n);
    else n_pass++;
    n_checks++;
    if ({act_dout[322], act_busy[322], act_ready[322]} !== 3'b001)
      $display("FAIL underrun_idle got %b want 001",
        {act_dout[322], act_busy[322], act_ready[322]});
    else n_pass++;
  endtask

  task automatic test_reset_mid_bit();
    int bad;
    data = 24'($urandom); last = 1'b0; valid1 = 1'b1;
    cyc();
    valid1 = 1'b0;
    repeat (11*13 + 3) cyc();
    n_checks++;
    if ({dout1, busy1} !== 2'b11) $display("FAIL midbit_pre dout/busy got %b want 11", {dout1, busy1});
    else n_pass++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if ({dout1, busy1, ready1} !== 3'b001)
      $display("FAIL midbit_reset dout/busy/ready got %b want 001", {dout1, busy1, ready1});
    else n_pass++;
    // Reset in the same cycle as a transfer drops the pixel.
    rst = 1'b1; valid1 = 1'b1; data = 24'($urandom); last = 1'b1;
    cyc();
    rst = 1'b0; valid1 = 1'b0;
    cyc();
    n_checks++;
    if ({dout1, busy1} !== 2'b00) $display("FAIL reset_xfer_drop dout/busy got %b want 00", {dout1, busy1});
    else n_pass++;
    feed_n = 1; feed_data[0] = 24'($urandom); feed_last[0] = 1'b1; feed_gap[0] = 0;
    build_model(0); run(0);
    bad = first_bad();
    n_checks++;
    if (bad >= 0) $display("FAIL after_reset_wave sample %0d dout/busy/ready got %b%b%b want %b%b%b", bad,
      act_dout[bad], act_busy[bad], act_ready[bad], exp_dout[bad], exp_busy[bad], exp_ready[bad]);
    else n_pass++;
  endtask

  task automatic test_param_override();
    int bad;
    feed_n = 3;
    feed_data[0] = 24'h000001;    feed_last[0] = 1'b1; feed_gap[0] = 0;
    feed_data[1] = 24'($urandom); feed_last[1] = 1'b0; feed_gap[1] = 0;
    feed_data[2] = 24'($urandom); feed_last[2] = 1'b1; feed_gap[2] = 0;
    build_model(1); run(1);
    bad = first_bad();
    n_checks++;
    if (bad >= 0) $display("FAIL param_wave sample %0d dout/busy/ready got %b%b%b want %b%b%b", bad,
      act_dout[bad], act_busy[bad], act_ready[bad], exp_dout[bad], exp_busy[bad], exp_ready[bad]);
    else n_pass++;
    n_checks++;
    if (!xfers_ok()) $display("FAIL param_xfer got %0d transfers want %0d at model times", act_nx, feed_n);
    else n_pass++;
  endtask

  task automatic test_random_frames();
    int bad;
    for (int it = 0; it < 3; it++) begin
      feed_n = 3;
      for (int i = 0; i < 3; i++) begin
        feed_data[i] = 24'($urandom);
        feed_last[i] = 1'($urandom_range(0, 1));
        feed_gap[i]  = ($urandom_range(0, 3) == 0) ? 311 : $urandom_range(0, 350);
      end
      build_model(it == 1); run(it == 1);
      bad = first_bad();
      n_checks++;
      if (bad >= 0) $display("FAIL random%0d_wave sample %0d dout/busy/ready got %b%b%b want %b%b%b", it, bad,
        act_dout[bad], act_busy[bad], act_ready[bad], exp_dout[bad], exp_busy[bad], exp_ready[bad]);
      else n_pass++;
      n_checks++;
      if (!xfers_ok()) $display("FAIL random%0d_xfer got %0d transfers want %0d", it, act_nx, feed_n);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_underrun();
    test_reset_mid_bit();
    test_param_override();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
